csr_seed_es: RTL

//  Zkr entropy-source CSR, successor to single-word seed CSR: gathers raw bits from NUM_CH noise channels into 16-bit words,

---
 rtl/zkr_pkg.sv | 35 +++
 rtl/seed_health.sv | 76 +++++++
 rtl/csr_seed_es.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/zkr_pkg.sv
// Shared definitions for the Zkr entropy-source seed CSR: OPST encoding, CSR address,
// mseccfg bit positions and the core-configuration record the seed CSR reads.
package zkr_pkg;

   typedef enum logic [1:0] {
      OpstBist = 2'b00,
      OpstWait = 2'b01,
      OpstEs16 = 2'b10,
      OpstDead = 2'b11
   } opst_t;

   localparam logic [11:0] SEED_CSR_ADR = 12'h015;
   localparam int unsigned USEED_BIT    = 8;
   localparam int unsigned SSEED_BIT    = 9;

   // Subset of the core configuration consumed by the seed CSR.
   typedef struct packed {
      int unsigned XLEN;
      logic [1:0]  M_MODE;
      logic [1:0]  S_MODE;
      logic [1:0]  U_MODE;
      logic        S_SUPPORTED;
      logic        U_SUPPORTED;
   } cvw_t;

   localparam cvw_t ZKR_DEFAULT_CFG = '{
      XLEN:        64,
      M_MODE:      2'b11,
      S_MODE:      2'b01,
      U_MODE:      2'b00,
      S_SUPPORTED: 1'b1,
      U_SUPPORTED: 1'b1
   };

endpackage

// File: rtl/seed_health.sv
// Health tests on completed 16-bit entropy words: repetition count (consecutive identical
// words) and adaptive proportion (low-byte matches against the first word of each window).
// fail pulses in the same cycle as the offending word's valid.
module seed_health #(
   parameter int unsigned RCT_CUTOFF = 4,
   parameter int unsigned APT_WINDOW = 64,
   parameter int unsigned APT_CUTOFF = 40
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] word,
   input  logic        valid,
   output logic        fail
);

   localparam int unsigned RctW = $clog2(RCT_CUTOFF + 1);
   localparam int unsigned AptW = $clog2(APT_WINDOW) + 1;

   logic [15:0]     last_q;
   logic            have_last_q;
   logic [RctW-1:0] rct_cnt_q, rct_cnt_d;
   logic [7:0]      apt_ref_q;
   logic [AptW-1:0] apt_idx_q, apt_idx_d;
   logic [AptW-1:0] apt_cnt_q, apt_cnt_d;
   logic            rct_fail, apt_fail;

   // Next counter values and the fail decision for the word presented this cycle
   always_comb begin
      rct_cnt_d = rct_cnt_q;
      apt_idx_d = apt_idx_q;
      apt_cnt_d = apt_cnt_q;
      rct_fail  = 1'b0;
      apt_fail  = 1'b0;
      if (valid) begin
         if (have_last_q && (word == last_q)) begin
            if (rct_cnt_q != RctW'(RCT_CUTOFF)) rct_cnt_d = rct_cnt_q + 1'b1;
         end else begin
            rct_cnt_d = RctW'(1);
         end
         rct_fail = (rct_cnt_d >= RctW'(RCT_CUTOFF));

         // Index 0 means this word opens a new window and becomes the reference.
         if (apt_idx_q == '0) begin
            apt_cnt_d = '0;
            apt_idx_d = AptW'(1);
         end else begin
            if (word[7:0] == apt_ref_q) apt_cnt_d = apt_cnt_q + 1'b1;
            apt_fail  = (apt_cnt_d > AptW'(APT_CUTOFF));
            apt_idx_d = (apt_idx_q == AptW'(APT_WINDOW - 1)) ? '0 : apt_idx_q + 1'b1;
         end
      end
      fail = rct_fail | apt_fail;
   end

   // Health-test state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q      <= '0;
         have_last_q <= 1'b0;
         rct_cnt_q   <= '0;
         apt_ref_q   <= '0;
         apt_idx_q   <= '0;
         apt_cnt_q   <= '0;
      end else begin
         rct_cnt_q <= rct_cnt_d;
         apt_idx_q <= apt_idx_d;
         apt_cnt_q <= apt_cnt_d;
         if (valid) begin
            last_q      <= word;
            have_last_q <= 1'b1;
            if (apt_idx_q == '0) apt_ref_q <= word[7:0];
         end
      end
   end

endmodule

// File: rtl/csr_seed_es.sv
// Zkr seed CSR (0x015) backed by an entropy source: noise assembler, health tests, word
// FIFO, OPST state machine and privilege-checked access decode.
// Build option: define SEED_SIM_LFSR_EN to replace NoiseBits/NoiseValid with an internal
// 32-bit Galois LFSR (simulation/FPGA only).
module csr_seed_es
   import zkr_pkg::*;
#(
   parameter cvw_t        P          = ZKR_DEFAULT_CFG,
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned BIST_WORDS = 16,
   parameter int unsigned RCT_CUTOFF = 4,
   parameter int unsigned APT_WINDOW = 64,
   parameter int unsigned APT_CUTOFF = 40
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        PrivilegeModeW,
   input  logic [63:0]       MSECCFG_REGW,
   input  logic [11:0]       CSRAdrM,
   input  logic              CSRWriteM,
   input  logic              SeedCommitM,
   input  logic              NoiseValid,
   input  logic [NUM_CH-1:0] NoiseBits,
   output logic [P.XLEN-1:0] SeedReadValM,
   output logic              IllegalSeedAccessM,
   output logic              SeedDead
);

   localparam int unsigned XLEN  = P.XLEN;
   localparam int unsigned Beats = 16 / NUM_CH;
   localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned BistW = $clog2(BIST_WORDS + 1);

   logic              noise_valid;
   logic [NUM_CH-1:0] noise_bits;

   logic [15:0]       asm_q, asm_shift;
   logic [BeatW-1:0]  beat_q;
   logic              word_done, health_fail;

   logic              push_q;
   logic [15:0]       push_word_q;

   logic [15:0]       fifo_mem [FIFO_DEPTH];
   logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]   count_q;
   logic              fifo_full, push, pop, go_dead;

   opst_t             state_q;
   logic [BistW-1:0]  bist_cnt_q;

   logic              adr_hit, priv_ok, legal;
   logic [31:0]       seed32;
   logic              unused_msec;

   assign unused_msec = ^{MSECCFG_REGW[63:10], MSECCFG_REGW[7:0]};

`ifdef SEED_SIM_LFSR_EN
   logic [31:0] lfsr_q;
   logic        unused_noise;

   assign unused_noise = ^{NoiseBits, NoiseValid};

   // Galois LFSR stepping once per cycle, low NUM_CH bits used as the sample
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) lfsr_q <= 32'hACE1_2345;
      else          lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ 32'h8020_0003) : (lfsr_q >> 1);
   end

   assign noise_valid = 1'b1;
   assign noise_bits  = lfsr_q[NUM_CH-1:0];
`else
   assign noise_valid = NoiseValid;
   assign noise_bits  = NoiseBits;
`endif

   // New samples enter at the top so the first sample ends up in the low bits.
   assign asm_shift = (asm_q >> NUM_CH) | (16'(noise_bits) << (16 - NUM_CH));
   assign word_done = noise_valid && (beat_q == BeatW'(Beats - 1));

   // Word assembler
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         asm_q  <= '0;
         beat_q <= '0;
      end else if (noise_valid) begin
         asm_q  <= asm_shift;
         beat_q <= word_done ? '0 : beat_q + 1'b1;
      end
   end

   seed_health #(
      .RCT_CUTOFF (RCT_CUTOFF),
      .APT_WINDOW (APT_WINDOW),
      .APT_CUTOFF (APT_CUTOFF)
   ) u_health (
      .clk     (clk),
      .reset_n (reset_n),
      .word    (asm_shift),
      .valid   (word_done),
      .fail    (health_fail)
   );

   // Stage a passing word for the FIFO one cycle after it completes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         push_q      <= 1'b0;
         push_word_q <= '0;
      end else begin
         push_q <= word_done && !health_fail &&
                   ((state_q == OpstWait) || (state_q == OpstEs16));
         if (word_done) push_word_q <= asm_shift;
      end
   end

   // Access decode; S/U only reach the seed when the mode exists and mseccfg allows it.
   assign adr_hit = (CSRAdrM == SEED_CSR_ADR);
   assign priv_ok = (PrivilegeModeW == P.M_MODE) ||
                    (P.S_SUPPORTED && (PrivilegeModeW == P.S_MODE) && MSECCFG_REGW[SSEED_BIT]) ||
                    (P.U_SUPPORTED && (PrivilegeModeW == P.U_MODE) && MSECCFG_REGW[USEED_BIT]);
   assign legal   = adr_hit && CSRWriteM && priv_ok;
   assign IllegalSeedAccessM = adr_hit && !legal;

   assign fifo_full = (count_q == CntW'(FIFO_DEPTH));
   assign pop       = SeedCommitM && legal && (state_q == OpstEs16);
   assign push      = push_q && (state_q != OpstDead) && (!fifo_full || pop);
   assign go_dead   = health_fail && (state_q != OpstDead);

   assign seed32       = {state_q, 14'b0, (state_q == OpstEs16) ? fifo_mem[rd_ptr_q] : 16'b0};
   assign SeedReadValM = legal ? XLEN'(seed32) : '0;

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push && !go_dead) fifo_mem[wr_ptr_q] <= push_word_q;
   end

   // FIFO pointers and occupancy; entering DEAD flushes everything
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (go_dead) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   // OPST state machine with BIST word counter and sticky dead alarm
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= OpstBist;
         bist_cnt_q <= '0;
         SeedDead   <= 1'b0;
      end else begin
         unique case (state_q)
            OpstBist: begin
               if (word_done) begin
                  if (health_fail) begin
                     state_q  <= OpstDead;
                     SeedDead <= 1'b1;
                  end else if (bist_cnt_q == BistW'(BIST_WORDS - 1)) begin
                     state_q <= OpstWait;
                  end else begin
                     bist_cnt_q <= bist_cnt_q + 1'b1;
                  end
               end
            end
            OpstWait: begin
               if (health_fail) begin
                  state_q  <= OpstDead;
                  SeedDead <= 1'b1;
               end else if (push) begin
                  state_q <= OpstEs16;
               end
            end
            OpstEs16: begin
               if (health_fail) begin
                  state_q  <= OpstDead;
                  SeedDead <= 1'b1;
               end else if (pop && (count_q == CntW'(1)) && !push) begin
                  state_q <= OpstWait;
               end
            end
            OpstDead: begin
               state_q <= OpstDead;
            end
         endcase
      end
   end

endmodule
